// File: rtl/ir_fetch.sv
// Instruction fetch / IR stage: owns the PC and fetches 1- or 2-byte instructions over req/ack.
// Optional fetch timeout is enabled with `define IFU_TIMEOUT_EN.
module ir_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ir2cu,
  output logic [DATA_W-1:0] operand,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err,
  output logic [1:0]        state_dbg
);

  // Memory handshake: mem_rd is asserted in both fetch states and held until a
  // cycle with mem_ack=1; data is taken on that edge. mem_ack is ignored otherwise.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_OP  = 2'd1,
    FETCH_ARG = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic              in_fetch;
  logic              op_latch;
  logic              arg_latch;
  logic              pc_inc;
  logic              timeout_hit;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("ir_fetch: TIMEOUT must be at least 1");
  end

  assign in_fetch  = (state == FETCH_OP) || (state == FETCH_ARG);
  assign mem_rd    = in_fetch;
  assign mem_addr  = pc;
  assign ir_valid  = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    op_latch  = 1'b0;
    arg_latch = 1'b0;
    pc_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req) state_nx = FETCH_OP;
      end
      FETCH_OP: begin
        if (mem_ack) begin
          op_latch = 1'b1;
          pc_inc   = 1'b1;
          // MSB of the opcode marks a two-byte instruction
          state_nx = mem_rdata[DATA_W-1] ? FETCH_ARG : DONE;
        end else if (timeout_hit) begin
          state_nx = DONE;
        end
      end
      FETCH_ARG: begin
        if (mem_ack) begin
          arg_latch = 1'b1;
          pc_inc    = 1'b1;
          state_nx  = DONE;
        end else if (timeout_hit) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // A jump loaded together with fetch_req takes effect before FETCH_OP drives the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= PC_RESET;
      ir2cu   <= '0;
      operand <= '0;
    end else begin
      if ((state == IDLE) && pc_load) pc <= pc_load_val;
      if (pc_inc)                     pc <= pc + ADDR_W'(1);
      if (op_latch) begin
        ir2cu <= mem_rdata;
        if (!mem_rdata[DATA_W-1]) operand <= '0;
      end
      if (arg_latch) operand <= mem_rdata;
      if (timeout_hit) begin
        ir2cu   <= '0;
        operand <= '0;
      end
    end
  end

`ifdef IFU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Counts unacknowledged request cycles; the TIMEOUT-th one gives up with a NOP.
  assign timeout_hit = in_fetch && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign fetch_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_nx != state)        wait_cnt <= '0;
      else if (in_fetch && !mem_ack) wait_cnt <= wait_cnt + CNT_W'(1);
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ir_fetch.sv
// Bench for ir_fetch: directed plan steps followed by randomized fetches against
// a byte-array program memory and an instruction-level reference model.
`timescale 1ns/1ps
module tb_ir_fetch;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 15;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_req = 1'b0;
  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_load_val = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] ir2cu;
  logic [DW-1:0] operand;
  logic          ir_valid;
  logic          busy;
  logic          fetch_err;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  ir_fetch #(.ADDR_W(AW), .DATA_W(DW), .PC_RESET('0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir2cu(ir2cu), .operand(operand),
    .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err), .state_dbg(state_dbg)
  );

  // ---------------- program memory + reference state ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            mem_wait  = 0;
  bit            mem_never = 1'b0;
  logic [AW-1:0] model_pc  = '0;
  logic          model_err = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;

  // Memory responder: ack after mem_wait wait cycles per request, random noise when idle.
  initial begin : mem_responder
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_rd && !mem_never && cnt >= mem_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        cnt       = 0;
      end else if (mem_rd) begin
        mem_ack   = 1'b0;
        mem_rdata = DW'($urandom);
        cnt++;
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
        cnt       = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Latency k counts rising edges after the edge that samples fetch_req until
  // ir_valid is seen: 1+w for one-byte, 2+2w for two-byte, TMO on timeout.
  task automatic do_fetch(input string tag, input bit load, input logic [AW-1:0] lval,
                          input int w, input bit expect_timeout);
    logic [DW-1:0] e_op;
    logic [DW-1:0] e_arg;
    logic [AW-1:0] a1;
    int            e_k;
    int            k;
    if (load) model_pc = lval;
    if (expect_timeout) begin
      e_op      = '0;
      e_arg     = '0;
      e_k       = TMO;
      model_err = 1'b1;
    end else begin
      e_op = mem[model_pc];
      a1   = model_pc + AW'(1);
      if (e_op[DW-1]) begin
        e_arg    = mem[a1];
        e_k      = 2 + 2 * w;
        model_pc = model_pc + AW'(2);
      end else begin
        e_arg    = '0;
        e_k      = 1 + w;
        model_pc = a1;
      end
    end
    @(negedge clk);
    fetch_req   = 1'b1;
    pc_load     = load;
    pc_load_val = lval;
    mem_wait    = w;
    @(posedge clk); #1;
    fetch_req   = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = AW'($urandom);
    k = 0;
    while (ir_valid !== 1'b1 && k < 100) begin
      chk({tag, "_mem_rd_held"}, 32'(mem_rd), 32'd1);
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_ir_valid"},  32'(ir_valid), 32'd1);
    chk({tag, "_latency"},   32'(k), 32'(e_k));
    chk({tag, "_ir2cu"},     32'(ir2cu), 32'(e_op));
    chk({tag, "_operand"},   32'(operand), 32'(e_arg));
    chk({tag, "_pc"},        32'(mem_addr), 32'(model_pc));
    chk({tag, "_done_rd"},   32'(mem_rd), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    chk({tag, "_fetch_err"}, 32'(fetch_err), 32'(model_err));
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 32'(ir_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_hold_ir"},   32'(ir2cu), 32'(e_op));
  endtask

  task automatic do_jump(input logic [AW-1:0] lval);
    @(negedge clk);
    pc_load     = 1'b1;
    pc_load_val = lval;
    @(posedge clk); #1;
    pc_load  = 1'b0;
    model_pc = lval;
    chk("jump_pc", 32'(mem_addr), 32'(model_pc));
    chk("jump_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_addr"},  32'(mem_addr), 32'h00);
    chk({tag, "_mem_rd"},    32'(mem_rd), 32'd0);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_ir_valid"},  32'(ir_valid), 32'd0);
    chk({tag, "_ir2cu"},     32'(ir2cu), 32'h00);
    chk({tag, "_operand"},   32'(operand), 32'h00);
    chk({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[8'h00] = 8'h12;
    mem[8'h01] = 8'h85;
    mem[8'h02] = 8'h3C;
    mem[8'hFF] = 8'h01;

    // reset held 60 ns, then released
    #55;
    chk_reset_outputs("in_reset");
    #5;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("after_reset");
    model_pc = '0;

    do_fetch("one_byte", 1'b0, '0, 0, 1'b0);
    do_fetch("two_byte_wait2", 1'b0, '0, 2, 1'b0);
    do_fetch("jump_ff_wrap", 1'b1, 8'hFF, 0, 1'b0);

    // reset in the middle of a waited fetch
    @(negedge clk);
    mem_wait  = 6;
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #3;
    chk("mid_fetch_rd_before", 32'(mem_rd), 32'd1);
    rst = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_pc = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(ir_valid), 32'd0);
    end
    chk("abort_pc", 32'(mem_addr), 32'h00);

    // randomized fetches, waits, jumps and idle gaps
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if ($urandom_range(0, 5) == 0) do_jump(AW'($urandom));
      do_fetch($sformatf("rand%0d", i), ($urandom_range(0, 3) == 0), AW'($urandom),
               int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef IFU_TIMEOUT_EN
    mem_never = 1'b1;
    do_fetch("timeout", 1'b0, '0, 0, 1'b1);
    mem_never = 1'b0;
    do_fetch("after_timeout", 1'b0, '0, 1, 1'b0);
`else
    chk("no_timeout_err", 32'(fetch_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_fetch.md
# ir_fetch

Instruction fetch and instruction-register stage directly upstream of the control unit `cu`. It owns the program counter and, on request from `cu`, reads one- or two-byte instructions from program memory over a req/ack handshake. It holds the opcode on `ir2cu`, which drives the `data_from_ir` input of `cu`, and holds any immediate operand on `operand`. It pulses `ir_valid` when a complete instruction is latched.

## Interface
Parameters:
- `ADDR_W`, 8: program counter and memory address width.
- `DATA_W`, 8: instruction byte width; `ir2cu` and `operand` width.
- `PC_RESET`, 0: PC value after reset.
- `TIMEOUT`, 15: max wait cycles for `mem_ack`; only used with `IFU_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  from `cu`: start a fetch at the current PC.
- `pc_load`  in  1  from `cu`: load `pc_load_val` into PC (jump).
- `pc_load_val`  in  ADDR_W  jump target.
- `mem_addr`  out  ADDR_W  program memory address.
- `mem_rd`  out  1  read request; held until acknowledged.
- `mem_rdata`  in  DATA_W  read data; valid when `mem_ack`=1.
- `mem_ack`  in  1  memory acknowledge.
- `ir2cu`  out  DATA_W  opcode register; feeds `cu.data_from_ir`.
- `operand`  out  DATA_W  immediate byte of two-byte instructions.
- `ir_valid`  out  1  one-cycle pulse: new instruction latched.
- `busy`  out  1  fetch in progress (state ≠ IDLE).
- `fetch_err`  out  1  sticky timeout error; constant 0 without `IFU_TIMEOUT_EN`.

## Operation
- States: IDLE, FETCH_OP, FETCH_ARG, DONE.
- IDLE:
  - `pc_load`=1 → PC ← `pc_load_val`.
  - `fetch_req`=1 → FETCH_OP.
  - If both are set in the same cycle, the fetch uses the new PC.
- FETCH_OP:
  - `mem_rd`=1, `mem_addr`=PC.
  - On `mem_ack`: `ir2cu` ← `mem_rdata`, PC ← PC+1.
  - If `mem_rdata[DATA_W-1]`=1 (two-byte opcode) → FETCH_ARG; otherwise `operand` ← 0 and → DONE.
- FETCH_ARG:
  - `mem_rd`=1, `mem_addr`=PC.
  - On `mem_ack`: `operand` ← `mem_rdata`, PC ← PC+1, → DONE.
- DONE: `ir_valid`=1 for exactly one cycle, `mem_rd`=0, → IDLE.
- `mem_addr` is always the PC, combinationally.
- PC increment wraps modulo 2^ADDR_W (0xFF+1 → 0x00).
- `fetch_req` and `pc_load` are ignored outside IDLE. `cu` must not issue them while `busy`=1.
- `mem_ack` is ignored in IDLE and DONE.
- `ir2cu` and `operand` keep their values until the next successful latch.
- `busy` = (state ≠ IDLE), combinational.

## Timing
- Reset (async, `rst`=0): state=IDLE, PC=PC_RESET, `mem_addr`=PC_RESET, `ir2cu`=0, `operand`=0, `ir_valid`=0, `busy`=0, `mem_rd`=0, `fetch_err`=0.
- Reset during a fetch aborts it immediately: `mem_rd` drops without waiting for a clock, and no partial instruction is reported.
- Zero-wait memory (ack in the first request cycle), `fetch_req` sampled at edge N:
  - one-byte instruction: `ir_valid` high in cycle N+2;
  - two-byte instruction: `ir_valid` high in cycle N+3.
- Each wait cycle (`mem_rd`=1, `mem_ack`=0) adds one cycle of latency.
- `mem_rd` stays high across back-to-back FETCH_OP→FETCH_ARG without a gap. The address changes at the edge that samples the first ack.
- Earliest next `fetch_req` is accepted in the cycle after `ir_valid`.

## Configuration
- `IFU_TIMEOUT_EN` defined:
  - a wait counter runs in FETCH_OP/FETCH_ARG and clears on each state entry;
  - when it reaches TIMEOUT without `mem_ack`: `fetch_err` ← 1 (sticky until reset), `ir2cu` ← 0 (NOP), `operand` ← 0, PC unchanged, → DONE, and `ir_valid` pulses.
- `IFU_TIMEOUT_EN` undefined: no counter, and the block waits indefinitely for `mem_ack`.

## Test plan
- Reset with `rst`=0 for 60 ns, then release → all outputs at reset values, `mem_addr`=0x00, `busy`=0.
- One-byte fetch, zero-wait memory returning 0x12 at address 0x00 → `ir2cu`=0x12, `operand`=0x00, `ir_valid` pulse 2 cycles after `fetch_req`, PC=0x01.
- Two-byte fetch: 0x85 at 0x01, 0x3C at 0x02, ack delayed 2 cycles each → `ir2cu`=0x85, `operand`=0x3C, PC=0x03, single `ir_valid` pulse.
- `pc_load` with `pc_load_val`=0xFF plus `fetch_req` in the same cycle, memory[0xFF]=0x01 → fetch from 0xFF, PC wraps to 0x00.
- `rst` asserted while `mem_rd`=1 mid-fetch → `mem_rd`=0 at once, no `ir_valid`, `ir2cu`=0.
- With `IFU_TIMEOUT_EN`, `mem_ack` never asserted → after 15 wait cycles: `fetch_err`=1, `ir2cu`=0x00, `ir_valid` pulse, PC unchanged.
